// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, single-outstanding imem fetch, instruction buffer
// Optional misaligned-redirect detection is built when IF_MISALIGN_CHK_EN is defined.
module if_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [63:0]   pc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [31:0]   data_mem [IBUF_DEPTH];
  logic [63:0]   pc_mem   [IBUF_DEPTH];

  logic          not_full;
  logic          gnt;
  logic          push;
  logic          pop;
  logic [63:0]   redir_target;
  logic          redir_misalign;
  logic          misalign_err;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;
  assign redir_target   = redirect_pc;
  assign redir_misalign = |redirect_pc[1:0];
  assign misalign_err   = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign redir_target   = {redirect_pc[63:2], 2'b00};
  assign redir_misalign = 1'b0;
  assign misalign_err   = 1'b0;
`endif

  assign not_full   = (count < DEPTH_C);
  assign imem_req   = (state == S_REQ) && not_full;
  assign imem_addr  = pc;
  assign gnt        = imem_req && imem_gnt;
  // Only a response to our own granted request (S_WAIT) is ever buffered.
  assign push       = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && id_ready && !redirect_valid;
  assign count_n    = count + CW'(push) - CW'(pop);
  assign inst       = inst_valid ? data_mem[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 64'h0;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (not_full && !misalign_err) state_n = S_REQ;
      S_REQ:  if (gnt) state_n = S_WAIT;
      S_WAIT: if (imem_rvalid) state_n = (count_n < DEPTH_C) ? S_REQ : S_IDLE;
      S_DROP: if (imem_rvalid) state_n = S_REQ;
      default: state_n = S_IDLE;
    endcase
    if (redirect_valid) begin
      // A response still in flight must be swallowed before fetching the new target.
      case (state)
        S_WAIT:  state_n = imem_rvalid ? S_REQ : S_DROP;
        S_REQ:   state_n = gnt ? S_DROP : S_REQ;
        S_DROP:  state_n = imem_rvalid ? S_REQ : S_DROP;
        default: state_n = S_REQ;
      endcase
      if (redir_misalign) state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
`ifdef IF_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        pc     <= redir_target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
`ifdef IF_MISALIGN_CHK_EN
        misalign_q <= redir_misalign;
`endif
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          pc     <= pc + 64'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a grant-budgeted imem responder
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int grants_allowed = 0;
  int grants_done    = 0;
  int extra_lat      = 0;
  logic [63:0] exp_q[$];

  assign imem_gnt = (grants_done < grants_allowed);

  if_stage dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
`ifdef IF_MISALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string nm);
    int i = 0;
    do begin @(negedge clk); i++; end while (!(imem_req && imem_gnt) && i < 60);
    chk(nm, {63'h0, imem_req && imem_gnt}, 64'h1);
  endtask

  task automatic wait_req(input string nm);
    int i = 0;
    do begin @(negedge clk); i++; end while (!imem_req && i < 60);
    chk(nm, {63'h0, imem_req}, 64'h1);
  endtask

  task automatic wait_valid(input string nm);
    int i = 0;
    do begin @(negedge clk); i++; end while (!inst_valid && i < 60);
    chk(nm, {63'h0, inst_valid}, 64'h1);
  endtask

  task automatic wait_drain(input string nm);
    int i = 0;
    do begin @(negedge clk); i++; end while (exp_q.size() != 0 && i < 200);
    chk(nm, 64'(exp_q.size()), 64'h0);
  endtask

  // Memory model: grant sampled mid-cycle, response extra_lat cycles after the grant cycle.
  initial begin
    logic        g, pend;
    logic [63:0] ga, paddr;
    int          dly;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend = 1'b0; paddr = 64'h0; dly = 0;
    forever begin
      @(negedge clk);
      g  = imem_req && imem_gnt;
      ga = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (g) begin
        pend = 1'b1; paddr = ga; dly = extra_lat;
        grants_done++;
      end
      if (pend) begin
        if (dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word(paddr);
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: every accepted head instruction must match the scoreboard front.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst && inst_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h required no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", inst_pc, e);
          chk("pop_inst", {32'h0, inst}, {32'h0, word(e)});
        end
      end
    end
  end

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_addr", imem_addr, 64'h8000_0000);
`ifdef IF_MISALIGN_CHK_EN
    chk("rst_misalign", {63'h0, fetch_misalign}, 64'h0);
`endif

    // Streaming fetch with immediate grant and single-cycle response.
    step();
    grants_allowed = 4; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h8000_0000 + 64'(4 * i));
    rst = 1'b1;
    @(negedge clk);
    chk("first_cycle_no_req", {63'h0, imem_req}, 64'h0);
    @(negedge clk);
    chk("second_cycle_req", {63'h0, imem_req}, 64'h1);
    chk("second_cycle_addr", imem_addr, 64'h8000_0000);
    wait_drain("drain_stream");
    @(negedge clk);
    chk("stream_next_addr", imem_addr, 64'h8000_0010);

    // Backpressure fills the buffer and stalls fetch.
    step();
    id_ready = 1'b0; grants_allowed += 2;
    repeat (10) @(negedge clk);
    chk("full_valid", {63'h0, inst_valid}, 64'h1);
    chk("full_no_req", {63'h0, imem_req}, 64'h0);
    chk("full_head_pc", inst_pc, 64'h8000_0010);
    chk("full_head_inst", {32'h0, inst}, {32'h0, word(64'h8000_0010)});
    step();
    exp_q.push_back(64'h8000_0010);
    exp_q.push_back(64'h8000_0014);
    exp_q.push_back(64'h8000_0018);
    grants_allowed += 1; id_ready = 1'b1;
    wait_drain("drain_full");

    // Redirect while a granted fetch is still in flight.
    step();
    grants_allowed += 1; extra_lat = 3;
    wait_grant("grant_before_redirect");
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    exp_q.push_back(64'h8000_1000);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("drop_no_valid", {63'h0, inst_valid}, 64'h0);
    chk("drop_no_req", {63'h0, imem_req}, 64'h0);
    wait_req("req_after_drop");
    chk("redirect_addr", imem_addr, 64'h8000_1000);
    step();
    extra_lat = 0; grants_allowed += 1;
    wait_drain("drain_redirect");

    // Redirect coinciding with a push and a pop.
    step();
    id_ready = 1'b0; grants_allowed += 1;
    wait_valid("fill_one");
    step();
    grants_allowed += 1;
    wait_grant("grant_before_collision");
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; id_ready = 1'b1;
    step();
    redirect_valid = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    chk("collision_flushed", {63'h0, inst_valid}, 64'h0);
    chk("collision_req", {63'h0, imem_req}, 64'h1);
    chk("collision_addr", imem_addr, 64'h8000_2000);
    step();
    grants_allowed += 1;
    wait_valid("refill_after_collision");
    chk("collision_new_pc", inst_pc, 64'h8000_2000);
    chk("collision_new_inst", {32'h0, inst}, {32'h0, word(64'h8000_2000)});

    // Asynchronous reset in the middle of a fetch.
    step();
    extra_lat = 3; grants_allowed += 1;
    wait_grant("grant_before_reset");
    step();
    rst = 1'b0;
    #1;
    chk("async_rst_req", {63'h0, imem_req}, 64'h0);
    chk("async_rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("async_rst_inst", {32'h0, inst}, 64'h0);
    chk("async_rst_inst_pc", inst_pc, 64'h0);
    repeat (2) step();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_req", {63'h0, imem_req}, 64'h1);
    chk("post_rst_addr", imem_addr, 64'h8000_0000);
    chk("stale_ignored", {63'h0, inst_valid}, 64'h0);
    step();
    extra_lat = 0; id_ready = 1'b1; grants_allowed += 1;
    exp_q.push_back(64'h8000_0000);
    wait_drain("drain_post_rst");

    // Redirect target alignment.
    step();
`ifdef IF_MISALIGN_CHK_EN
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("misalign_set", {63'h0, fetch_misalign}, 64'h1);
    chk("misalign_no_req", {63'h0, imem_req}, 64'h0);
    repeat (3) @(negedge clk);
    chk("misalign_sticky", {63'h0, fetch_misalign}, 64'h1);
    chk("misalign_still_no_req", {63'h0, imem_req}, 64'h0);
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0010;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("misalign_cleared", {63'h0, fetch_misalign}, 64'h0);
`else
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0012;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
`endif
    chk("aligned_req", {63'h0, imem_req}, 64'h1);
    chk("aligned_addr", imem_addr, 64'h8000_0010);
    step();
    grants_allowed += 1;
    exp_q.push_back(64'h8000_0010);
    wait_drain("drain_aligned");
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage. Owns the 64-bit PC and issues one 32-bit instruction fetch at a time to instruction memory.
- Buffers returned instructions in a small FIFO and presents them with their PC to id_stage through a valid/ready handshake.
- Accepts PC redirects (jumps, taken branches) from downstream; a redirect flushes the buffer and drops stale responses.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
- IBUF_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- redirect_valid  input  1  load redirect_pc as next fetch PC; flush buffer
- redirect_pc  input  64  redirect target
- id_ready  input  1  id_stage consumes head instruction this cycle
- imem_req  output  1  fetch request valid
- imem_addr  output  64  fetch address (current PC)
- imem_gnt  input  1  memory accepts request this cycle (imem_req && imem_gnt)
- imem_rvalid  input  1  response data valid; >= 1 cycle after grant, in order
- imem_rdata  input  32  fetched instruction
- inst_valid  output  1  buffer head valid
- inst  output  32  head instruction
- inst_pc  output  64  PC of head instruction

Behaviour:
- Reset (rst low, async):
  - pc = RESET_PC; FIFO empty; state = S_IDLE.
  - imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_DROP.
- S_IDLE: move to S_REQ when FIFO count < IBUF_DEPTH. The first imem_req is therefore asserted in the 2nd cycle after reset release.
- S_REQ: imem_req = 1, imem_addr = pc. On imem_gnt go to S_WAIT. If the FIFO is full, imem_req = 0 and the state stays S_REQ.
- S_WAIT:
  - On imem_rvalid: push {pc, imem_rdata}; pc = pc + 4 (64-bit wrap).
  - Then go to S_REQ if space remains after the push, else S_IDLE.
- Space reservation: a request is issued only when count < IBUF_DEPTH with no outstanding request, so a push can never overflow.
- Max one outstanding request; imem_req = 0 in S_WAIT, S_DROP and S_IDLE.
- Output:
  - inst_valid = (count != 0); inst and inst_pc are the head entry, zero when empty.
  - Pop on inst_valid && id_ready. Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (highest priority; overrides push/pop in the same cycle):
  - pc = redirect_pc; FIFO flushed, so inst_valid = 0 next cycle.
  - S_WAIT, or S_REQ with imem_gnt the same cycle: go to S_DROP. The next imem_rvalid is discarded (no push, no pc increment), then go to S_REQ.
  - S_WAIT with imem_rvalid the same cycle: the response is discarded, go to S_REQ (no DROP).
  - S_REQ without gnt: stay S_REQ; next cycle imem_addr = redirect_pc (an ungranted request may change address).
  - S_IDLE: go to S_REQ.
  - S_DROP: stay S_DROP.
- FIFO: read/write pointers of log2(IBUF_DEPTH) bits wrap naturally; count is log2(IBUF_DEPTH)+1 bits.
- Reset mid-operation clears everything asynchronously. Any response arriving after reset release with no grant outstanding is ignored.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Enabled:
  - Adds output port fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 loads pc but enters S_IDLE with a sticky error. No request is issued, and fetch_misalign = 1 until the next aligned redirect or reset.
- Disabled: no port; redirect_pc[1:0] is forced to 0 when loaded.

Test Plan:
- Reset release, memory grants immediately, rvalid 1 cycle after grant, id_ready = 1 -> imem_addr 0x80000000, 0x80000004, 0x80000008...; inst_pc tracks each; inst equals the returned data.
- id_ready = 0 -> after 2 responses inst_valid = 1, FIFO full, imem_req = 0. Raise id_ready -> pops in order; fetch resumes with address 0x80000008.
- Grant 0x80000004, then redirect to 0x80001000 before rvalid -> returned word dropped; next imem_addr 0x80001000; inst_valid = 0 until its response; inst_pc = 0x80001000.
- Redirect asserted in the same cycle as a pop and a push -> FIFO empty next cycle, pc = redirect_pc, no stale instruction ever presented.
- Assert rst mid S_WAIT -> outputs zero immediately; after release first imem_addr = 0x80000000.
- With IF_MISALIGN_CHK_EN: redirect to 0x80000002 -> fetch_misalign = 1, imem_req stays 0; redirect to 0x80000010 -> fetch_misalign = 0, fetch resumes at 0x80000010.
